// File: rtl/wdog_timer_ctrl.sv
// Watchdog sequencing core: prescaled down-counter, refresh window check, two-stage timeout.
// Latency: state, counter and flags update one pclk after the causing event; outputs are register-driven.
// Backpressure: none; strobes are single-cycle and always accepted (or ignored outside RUN/WARN).
module wdog_timer_ctrl #(
  parameter int          WDOG_CNT  = 16,
  parameter logic [7:0]  FEED_KEY  = 8'hAA,
  parameter int          RST_PULSE = 16
) (
  input  logic                pclk,
  input  logic                preset_n,
  input  logic                cr_wdga,
  input  logic [WDOG_CNT-1:0] cr_time,
  input  logic                cr_ie,
  input  logic [WDOG_CNT-1:0] cfg_window,
  input  logic [1:0]          cfg_presc,
  input  logic                feed_wr,
  input  logic [7:0]          feed_key,
  input  logic                irq_clr,
  input  logic                rstflag_clr,
  output logic [WDOG_CNT-1:0] sr_timer,
  output logic                sr_rstflag,
  output logic                wdog_irq,
  output logic                wdog_rst_req,
  output logic                wdog_active
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WARN, S_RST} state_t;

  state_t              state, state_nxt;
  logic [WDOG_CNT-1:0] counter, counter_nxt;
  logic [5:0]          presc_cnt, presc_nxt;
  logic [5:0]          presc_mask;
  logic [PW-1:0]       pulse_cnt, pulse_nxt;
  logic                wdga_q;
  logic                irq, irq_nxt;
  logic                rstflag, rstflag_nxt;
  logic                counting, tick, window_ok, feed_ok;
  logic                irq_set, rst_enter;

  // Prescaler terminal count for divide-by 1/4/16/64.
  always_comb begin
    presc_mask = 6'd0;
    case (cfg_presc)
      2'd0: presc_mask = 6'd0;
      2'd1: presc_mask = 6'd3;
      2'd2: presc_mask = 6'd15;
      default: presc_mask = 6'd63;
    endcase
  end

  assign counting  = (state == S_RUN) || (state == S_WARN);
  assign tick      = counting && (presc_cnt == presc_mask);
  // All-ones window means "refresh allowed anywhere".
  assign window_ok = (&cfg_window) || (counter <= cfg_window);
  assign feed_ok   = (feed_key == FEED_KEY) && window_ok;

  // Next-state and datapath: a feed in RUN/WARN takes priority over the same-cycle tick/timeout.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    presc_nxt   = counting ? presc_cnt + 6'd1 : 6'd0;
    pulse_nxt   = pulse_cnt;
    irq_set     = 1'b0;
    rst_enter   = 1'b0;

    case (state)
      S_IDLE: begin
        if (cr_wdga && !wdga_q) begin
          state_nxt   = S_RUN;
          counter_nxt = cr_time;
        end
      end
      S_RUN, S_WARN: begin
        if (feed_wr) begin
          if (feed_ok) begin
            counter_nxt = cr_time;
            presc_nxt   = 6'd0;
            state_nxt   = S_RUN;
          end else begin
            rst_enter = 1'b1;
          end
        end else if (tick) begin
          presc_nxt = 6'd0;
          if (counter != '0) begin
            counter_nxt = counter - 1'b1;
          end else if ((state == S_RUN) && cr_ie) begin
            state_nxt   = S_WARN;
            irq_set     = 1'b1;
            counter_nxt = cr_time;
          end else begin
            rst_enter = 1'b1;
          end
        end
      end
      S_RST: begin
        if (pulse_cnt == PULSE_LAST) begin
          state_nxt = S_IDLE;
          pulse_nxt = '0;
        end else begin
          pulse_nxt = pulse_cnt + 1'b1;
        end
      end
    endcase

    if (rst_enter) begin
      state_nxt   = S_RST;
      counter_nxt = '0;
      pulse_nxt   = '0;
    end

    // Prescaler phase restarts whenever the state moves.
    if (state_nxt != state) begin
      presc_nxt = 6'd0;
    end

    // Sets win over same-cycle software clears.
    irq_nxt     = irq_set   | (irq     & ~irq_clr);
    rstflag_nxt = rst_enter | (rstflag & ~rstflag_clr);
  end

  // State and datapath registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= S_IDLE;
      counter   <= '0;
      presc_cnt <= 6'd0;
      pulse_cnt <= '0;
      wdga_q    <= 1'b0;
      irq       <= 1'b0;
      rstflag   <= 1'b0;
    end else begin
      state     <= state_nxt;
      counter   <= counter_nxt;
      presc_cnt <= presc_nxt;
      pulse_cnt <= pulse_nxt;
      wdga_q    <= cr_wdga;
      irq       <= irq_nxt;
      rstflag   <= rstflag_nxt;
    end
  end

  assign sr_timer     = counter;
  assign sr_rstflag   = rstflag;
  assign wdog_irq     = irq;
  assign wdog_rst_req = (state == S_RST);
  assign wdog_active  = (state != S_IDLE);

endmodule
